// File: rtl/pet_needs_if.sv
// pet_needs_if -- signal bundle between the needs engine and its consumer
// (top-level pet FSM / OLED packer).
//
// Signals:
//   run        FSM is past START; enables decay and life update
//   act_eat    1-cycle action pulse, food += EAT_AMOUNT
//   act_play   1-cycle action pulse, fun += PLAY_AMOUNT
//   act_sleep  1-cycle action pulse, rest = 100
//   act_heal   1-cycle action pulse, life += HEAL_AMOUNT while diseased
//   life/food/fun/rest  7-bit need values, 0..100
//   disease    life <= DISEASE_TH (registered from life)
//   death      pet dead (registered from life)
//   tick       1-cycle decay tick pulse
//
// Modports:
//   master  consumer side: drives run and actions, reads the needs
//   slave   needs engine side
interface pet_needs_if;
  logic       run;
  logic       act_eat;
  logic       act_play;
  logic       act_sleep;
  logic       act_heal;
  logic [6:0] life;
  logic [6:0] food;
  logic [6:0] fun;
  logic [6:0] rest;
  logic       disease;
  logic       death;
  logic       tick;

  modport master (
    output run, act_eat, act_play, act_sleep, act_heal,
    input  life, food, fun, rest, disease, death, tick
  );

  modport slave (
    input  run, act_eat, act_play, act_sleep, act_heal,
    output life, food, fun, rest, disease, death, tick
  );
endinterface

// File: rtl/pet_needs.sv
// pet_needs -- needs engine for the virtual pet.
//
// Owns the life/food/fun/rest counters (0..100), decays the needs on a fixed
// tick time base, applies eat/play/sleep/heal actions and derives the
// disease and death flags from the registered life value.
//
// Ports:
//   clk        system clock (50 MHz)
//   btn_reset  synchronous active-low reset
//   if_needs   pet_needs_if.slave: run, act_* in; life, food, fun, rest,
//              disease, death, tick out (all outputs registered)
//
// Configuration macro:
//   PET_DEATH_LATCH_EN  defined: death is sticky until reset and freezes all
//                       state. Undefined: death simply mirrors life == 0
//                       (one cycle late) and the pet can recover.
module pet_needs #(
  parameter int TICK_CYCLES = 5000000,
  parameter int FOOD_PERIOD = 10,
  parameter int FUN_PERIOD  = 8,
  parameter int REST_PERIOD = 12,
  parameter int LIFE_PLUS   = 70,
  parameter int LIFE_MINUS  = 30,
  parameter int DISEASE_TH  = 20,
  parameter int EAT_AMOUNT  = 25,
  parameter int PLAY_AMOUNT = 20,
  parameter int HEAL_AMOUNT = 30
) (
  input  logic       clk,
  input  logic       btn_reset,
  pet_needs_if.slave if_needs
);

  localparam int TW  = $clog2(TICK_CYCLES);
  localparam int FPW = (FOOD_PERIOD > 1) ? $clog2(FOOD_PERIOD) : 1;
  localparam int UPW = (FUN_PERIOD  > 1) ? $clog2(FUN_PERIOD)  : 1;
  localparam int RPW = (REST_PERIOD > 1) ? $clog2(REST_PERIOD) : 1;

  localparam logic [TW-1:0]  C_TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [FPW-1:0] C_FOOD_LAST = FPW'(FOOD_PERIOD - 1);
  localparam logic [UPW-1:0] C_FUN_LAST  = UPW'(FUN_PERIOD - 1);
  localparam logic [RPW-1:0] C_REST_LAST = RPW'(REST_PERIOD - 1);

  localparam logic [6:0] C_LIFE_PLUS  = 7'(LIFE_PLUS);
  localparam logic [6:0] C_LIFE_MINUS = 7'(LIFE_MINUS);
  localparam logic [6:0] C_DIS_TH     = 7'(DISEASE_TH);
  localparam logic [6:0] C_FULL       = 7'd100;

  localparam logic signed [8:0] C_EAT  = 9'(EAT_AMOUNT);
  localparam logic signed [8:0] C_PLAY = 9'(PLAY_AMOUNT);
  localparam logic signed [8:0] C_HEAL = 9'(HEAL_AMOUNT);

  logic [TW-1:0]  r_tick_cnt;
  logic [FPW-1:0] r_food_cnt;
  logic [UPW-1:0] r_fun_cnt;
  logic [RPW-1:0] r_rest_cnt;
  logic           r_tick;
  logic [6:0]     r_life;
  logic [6:0]     r_food;
  logic [6:0]     r_fun;
  logic [6:0]     r_rest;
  logic           r_disease;
  logic           r_death;

  logic                w_frozen;
  logic                w_upd;
  logic                w_food_dec;
  logic                w_fun_dec;
  logic                w_rest_dec;
  logic                w_eat;
  logic                w_play;
  logic                w_sleep;
  logic                w_heal;
  logic [1:0]          w_n_plus;
  logic [1:0]          w_n_minus;
  logic signed [8:0]   w_delta;
  logic signed [8:0]   w_food_sum;
  logic signed [8:0]   w_fun_sum;
  logic signed [8:0]   w_rest_sum;
  logic signed [8:0]   w_life_sum;

  // Clamp a signed 9-bit intermediate into the 0..100 need range.
  function automatic logic [6:0] sat100(input logic signed [8:0] v);
    if (v < 9'sd0) begin
      return 7'd0;
    end else if (v > 9'sd100) begin
      return C_FULL;
    end else begin
      return v[6:0];
    end
  endfunction

  always_comb begin
`ifdef PET_DEATH_LATCH_EN
    w_frozen = r_death;
`else
    w_frozen = 1'b0;
`endif
    w_upd      = r_tick & if_needs.run & ~w_frozen;
    w_food_dec = w_upd & (r_food_cnt == C_FOOD_LAST);
    w_fun_dec  = w_upd & (r_fun_cnt  == C_FUN_LAST);
    w_rest_dec = w_upd & (r_rest_cnt == C_REST_LAST);

    w_eat   = if_needs.act_eat   & ~w_frozen;
    w_play  = if_needs.act_play  & ~w_frozen;
    w_sleep = if_needs.act_sleep & ~w_frozen;
    // Heal only counts while the registered disease flag is already set.
    w_heal  = if_needs.act_heal  & r_disease & ~w_frozen;

    // Life delta is judged on the needs held before this edge, so decay and
    // actions landing on the same edge do not feed back into it.
    w_n_plus  = 2'(r_food >= C_LIFE_PLUS) + 2'(r_fun >= C_LIFE_PLUS)
              + 2'(r_rest >= C_LIFE_PLUS);
    w_n_minus = 2'(r_food <= C_LIFE_MINUS) + 2'(r_fun <= C_LIFE_MINUS)
              + 2'(r_rest <= C_LIFE_MINUS);
    w_delta   = w_upd ? ($signed({7'd0, w_n_plus}) - $signed({7'd0, w_n_minus}))
                      : 9'sd0;

    w_food_sum = $signed({2'b00, r_food}) - (w_food_dec ? 9'sd1 : 9'sd0)
               + (w_eat ? C_EAT : 9'sd0);
    w_fun_sum  = $signed({2'b00, r_fun}) - (w_fun_dec ? 9'sd1 : 9'sd0)
               + (w_play ? C_PLAY : 9'sd0);
    w_rest_sum = $signed({2'b00, r_rest}) - (w_rest_dec ? 9'sd1 : 9'sd0);
    w_life_sum = $signed({2'b00, r_life}) + w_delta
               + (w_heal ? C_HEAL : 9'sd0);
  end

  always_ff @(posedge clk) begin
    if (!btn_reset) begin
      r_tick_cnt <= '0;
      r_food_cnt <= '0;
      r_fun_cnt  <= '0;
      r_rest_cnt <= '0;
      r_tick     <= 1'b0;
      r_life     <= C_FULL;
      r_food     <= C_FULL;
      r_fun      <= C_FULL;
      r_rest     <= C_FULL;
      r_disease  <= 1'b0;
      r_death    <= 1'b0;
    end else begin
      // Time base is free-running; run only gates what a tick does.
      if (r_tick_cnt == C_TICK_LAST) begin
        r_tick_cnt <= '0;
        r_tick     <= 1'b1;
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
        r_tick     <= 1'b0;
      end

      if (w_upd) begin
        r_food_cnt <= w_food_dec ? '0 : r_food_cnt + FPW'(1);
        r_fun_cnt  <= w_fun_dec  ? '0 : r_fun_cnt  + UPW'(1);
        r_rest_cnt <= w_rest_dec ? '0 : r_rest_cnt + RPW'(1);
      end

      r_food <= sat100(w_food_sum);
      r_fun  <= sat100(w_fun_sum);
      r_rest <= w_sleep ? C_FULL : sat100(w_rest_sum);
      r_life <= sat100(w_life_sum);

      r_disease <= (r_life <= C_DIS_TH);
`ifdef PET_DEATH_LATCH_EN
      r_death   <= r_death | (r_life == 7'd0);
`else
      r_death   <= (r_life == 7'd0);
`endif
    end
  end

  assign if_needs.life    = r_life;
  assign if_needs.food    = r_food;
  assign if_needs.fun     = r_fun;
  assign if_needs.rest    = r_rest;
  assign if_needs.disease = r_disease;
  assign if_needs.death   = r_death;
  assign if_needs.tick    = r_tick;

endmodule

// File: tb/tb_pet_needs.sv
// tb_pet_needs -- bench for pet_needs with a 4-cycle tick and all periods 1.
// A behavioural cycle model pushes the expected outputs of every driven
// cycle into a queue that is popped and compared one cycle later; a table of
// stimulus rows additionally carries hand-derived values checked at the end
// of each row.
module tb_pet_needs;
  localparam int TICK = 4;
  localparam int FP   = 1;
  localparam int UP   = 1;
  localparam int RP   = 1;
  localparam int LP   = 70;
  localparam int LM   = 30;
  localparam int DTH  = 20;
  localparam int EAT  = 25;
  localparam int PLAY = 20;
  localparam int HEAL = 30;

  logic clk = 1'b0;
  logic btn_reset = 1'b0;
  always #5 clk = ~clk;

  pet_needs_if nif();

  pet_needs #(
    .TICK_CYCLES(TICK), .FOOD_PERIOD(FP), .FUN_PERIOD(UP), .REST_PERIOD(RP),
    .LIFE_PLUS(LP), .LIFE_MINUS(LM), .DISEASE_TH(DTH),
    .EAT_AMOUNT(EAT), .PLAY_AMOUNT(PLAY), .HEAL_AMOUNT(HEAL)
  ) dut (
    .clk(clk),
    .btn_reset(btn_reset),
    .if_needs(nif)
  );

  typedef struct packed {
    logic [6:0] life;
    logic [6:0] food;
    logic [6:0] fun;
    logic [6:0] rest;
    logic       dis;
    logic       death;
    logic       tick;
  } obs_t;

  typedef struct {
    bit run, eat, play, sleep, heal;
    int ncyc;
    bit chk;
    int life, food, fun, rest;
    bit dis, death;
  } vec_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int m_life, m_food, m_fun, m_rest, m_cnt, m_fc, m_uc, m_rc;
  bit m_dis, m_death, m_tick;

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 100) ? 100 : v);
  endfunction

  task automatic model_reset();
    m_life = 100; m_food = 100; m_fun = 100; m_rest = 100;
    m_cnt = 0; m_fc = 0; m_uc = 0; m_rc = 0;
    m_dis = 0; m_death = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit run, eat, play, sleep, heal);
    bit frozen, upd, fd, ud, rd, n_dis, n_death, n_tick;
    int delta, n_life, n_food, n_fun, n_rest;
`ifdef PET_DEATH_LATCH_EN
    frozen = m_death;
`else
    frozen = 1'b0;
`endif
    upd = m_tick && run && !frozen;
    fd = upd && (m_fc == FP - 1);
    ud = upd && (m_uc == UP - 1);
    rd = upd && (m_rc == RP - 1);
    if (upd) begin
      m_fc = fd ? 0 : m_fc + 1;
      m_uc = ud ? 0 : m_uc + 1;
      m_rc = rd ? 0 : m_rc + 1;
    end
    delta = 0;
    if (upd)
      delta = int'(m_food >= LP) + int'(m_fun >= LP) + int'(m_rest >= LP)
            - int'(m_food <= LM) - int'(m_fun <= LM) - int'(m_rest <= LM);
    n_food = sat(m_food - int'(fd) + ((eat && !frozen) ? EAT : 0));
    n_fun  = sat(m_fun - int'(ud) + ((play && !frozen) ? PLAY : 0));
    n_rest = (sleep && !frozen) ? 100 : sat(m_rest - int'(rd));
    n_life = sat(m_life + delta + ((heal && m_dis && !frozen) ? HEAL : 0));
    n_dis  = (m_life <= DTH);
`ifdef PET_DEATH_LATCH_EN
    n_death = m_death || (m_life == 0);
`else
    n_death = (m_life == 0);
`endif
    n_tick = (m_cnt == TICK - 1);
    m_cnt  = n_tick ? 0 : m_cnt + 1;
    m_life = n_life; m_food = n_food; m_fun = n_fun; m_rest = n_rest;
    m_dis = n_dis; m_death = n_death; m_tick = n_tick;
  endtask

  task automatic check_obs(input string name, input obs_t e);
    checks++;
    if (nif.life !== e.life || nif.food !== e.food || nif.fun !== e.fun ||
        nif.rest !== e.rest || nif.disease !== e.dis ||
        nif.death !== e.death || nif.tick !== e.tick) begin
      errors++;
      $display("FAIL %s t=%0t: got life=%0d food=%0d fun=%0d rest=%0d dis=%b death=%b tick=%b, want life=%0d food=%0d fun=%0d rest=%0d dis=%b death=%b tick=%b",
               name, $time, nif.life, nif.food, nif.fun, nif.rest, nif.disease,
               nif.death, nif.tick, e.life, e.food, e.fun, e.rest, e.dis,
               e.death, e.tick);
    end
  endtask

  task automatic check_hand(input string name, input int l, f, u, r,
                            input bit d, dt);
    checks++;
    if (nif.life !== 7'(l) || nif.food !== 7'(f) || nif.fun !== 7'(u) ||
        nif.rest !== 7'(r) || nif.disease !== d || nif.death !== dt) begin
      errors++;
      $display("FAIL %s: got life=%0d food=%0d fun=%0d rest=%0d dis=%b death=%b, want life=%0d food=%0d fun=%0d rest=%0d dis=%b death=%b",
               name, nif.life, nif.food, nif.fun, nif.rest, nif.disease,
               nif.death, l, f, u, r, d, dt);
    end
  endtask

  task automatic step(input bit run, eat, play, sleep, heal);
    obs_t e;
    @(negedge clk);
    nif.run = run; nif.act_eat = eat; nif.act_play = play;
    nif.act_sleep = sleep; nif.act_heal = heal;
    model_step(run, eat, play, sleep, heal);
    e.life = 7'(m_life); e.food = 7'(m_food); e.fun = 7'(m_fun);
    e.rest = 7'(m_rest); e.dis = m_dis; e.death = m_death; e.tick = m_tick;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      check_obs("cycle", e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_reset = 1'b0;
    nif.run = 0; nif.act_eat = 0; nif.act_play = 0;
    nif.act_sleep = 0; nif.act_heal = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    check_hand("reset", 100, 100, 100, 100, 1'b0, 1'b0);
    checks++;
    if (nif.tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: got %b, want 0", nif.tick);
    end
    btn_reset = 1'b1;
  endtask

  function automatic vec_t mk(input bit run, eat, play, sleep, heal,
                              input int ncyc, input bit chk,
                              input int l, f, u, r, input bit d, dt);
    vec_t v;
    v.run = run; v.eat = eat; v.play = play; v.sleep = sleep; v.heal = heal;
    v.ncyc = ncyc; v.chk = chk;
    v.life = l; v.food = f; v.fun = u; v.rest = r; v.dis = d; v.death = dt;
    return v;
  endfunction

  task automatic run_row(input int idx, input vec_t v);
    for (int c = 0; c < v.ncyc; c++) begin
      if (c == 0) step(v.run, v.eat, v.play, v.sleep, v.heal);
      else        step(v.run, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (v.chk)
      check_hand($sformatf("row%0d", idx), v.life, v.food, v.fun, v.rest,
                 v.dis, v.death);
  endtask

  vec_t vecs[16];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nif.run = 0; nif.act_eat = 0; nif.act_play = 0;
    nif.act_sleep = 0; nif.act_heal = 0;

    //            run eat ply slp hel ncyc chk life food fun rest dis death
    vecs[0]  = mk(0, 0, 0, 0, 1,   1, 1, 100, 100, 100, 100, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0,   9, 1, 100, 100, 100, 100, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 160, 1, 100,  60,  60,  60, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 228, 1,  19,   3,   3,   3, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 1,   2, 1,  49,   3,   3,   3, 0, 0);
    vecs[5]  = mk(1, 1, 1, 1, 0,   1, 1,  46,  27,  22, 100, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 157, 1,   0,   0,   0,  61, 1, 1);
`ifdef PET_DEATH_LATCH_EN
    vecs[7]  = mk(0, 1, 0, 0, 0,   1, 1,   0,   0,   0,  61, 1, 1);
`else
    vecs[7]  = mk(0, 1, 0, 0, 0,   1, 1,   0,  25,   0,  61, 1, 1);
`endif
    vecs[8]  = mk(0, 1, 0, 0, 0,   1, 0,   0,   0,   0,   0, 0, 0);
    vecs[9]  = mk(0, 1, 1, 0, 0,   1, 0,   0,   0,   0,   0, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 0,   1, 0,   0,   0,   0,   0, 0, 0);
    vecs[11] = mk(0, 0, 1, 0, 0,   1, 0,   0,   0,   0,   0, 0, 0);
`ifdef PET_DEATH_LATCH_EN
    vecs[12] = mk(0, 0, 1, 1, 0,   1, 1,   0,   0,   0,  61, 1, 1);
    vecs[13] = mk(1, 0, 0, 0, 0,   2, 1,   0,   0,   0,  61, 1, 1);
`else
    vecs[12] = mk(0, 0, 1, 1, 0,   1, 1,   0,  75,  80, 100, 1, 1);
    vecs[13] = mk(1, 0, 0, 0, 0,   2, 1,   3,  74,  79,  99, 1, 0);
`endif
    // after a mid-operation reset: eat and sleep land on the 11th update
    vecs[14] = mk(1, 0, 0, 0, 0,  44, 1, 100,  90,  90,  90, 0, 0);
    vecs[15] = mk(1, 1, 0, 1, 0,   1, 1, 100, 100,  89, 100, 0, 0);

    do_reset();
    for (int i = 0; i < 14; i++) run_row(i, vecs[i]);
    do_reset();
    for (int i = 14; i < 16; i++) run_row(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
